bus_strobe_seq: RTL
===================

BUS_STROBE_SEQ -- requirements
Module: bus_strobe_seq

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: fclk cycles with address/data valid before the strobe falls (range 1..7).
REQ-002 Parameter STB_CYCLES, default 4: fclk cycles brd_n/bwr_n are held low (range 1..15).
REQ-003 Parameter HOLD_CYCLES, default 1: fclk cycles after the strobe rises before bd is released (range 1..7).
REQ-004 fclk  in  1  sole clock, filter clock, rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 zrd_n  in  1  raw Z80 read strobe, asynchronous to fclk.
REQ-007 zwr_n  in  1  raw Z80 write strobe, asynchronous to fclk.
REQ-008 acc_sel  in  1  decoded "access targets W5300/SL811", asynchronous, valid while the strobe is low.
REQ-009 zd_in  in  8  Z80 data bus input.
REQ-010 zd_out / zd_oe  out  8/1  read data to Z80, and its output enable.
REQ-011 bd_in  in  8  peripheral data bus input.
REQ-012 bd_out / bd_oe  out  8/1  write data to peripheral, and its output enable.
REQ-013 brd_n / bwr_n  out  1/1  peripheral read/write strobes, active-low, registered.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 zrd_n, zwr_n and acc_sel SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized copies.
REQ-016 FSM states: IDLE, SETUP, STROBE, HOLD, WAIT_END.
REQ-017 IDLE -> SETUP when acc_sel=1 and exactly one of the synced strobes is 0; this latches the direction (rnw), and for writes latches zd_in into bd_out.
REQ-018 When both synced strobes are 0, or acc_sel=0, the FSM SHALL stay in IDLE with no peripheral strobe.
REQ-019 SETUP lasts SETUP_CYCLES, then -> STROBE; bd_oe=1 for writes from SETUP entry through HOLD exit.
REQ-020 STROBE lasts STB_CYCLES with brd_n=0 (read) or bwr_n=0 (write), then -> HOLD.
REQ-021 Latency: the strobe falls at the (3+SETUP_CYCLES)th fclk edge, counting the first edge that samples the raw strobe low as edge 1.
REQ-022 A read SHALL capture bd_in into the read register on the last STROBE cycle.
REQ-023 HOLD lasts HOLD_CYCLES with both strobes high, then -> WAIT_END.
REQ-024 WAIT_END -> IDLE on the first cycle the synced CPU strobe is 1; exactly one peripheral access per CPU strobe.
REQ-025 If the CPU strobe rises during SETUP or STROBE, the access SHALL still complete full length (no truncation), then go through WAIT_END to IDLE.
REQ-026 Phase counter: 4 bits, reloaded on each state entry, never wraps; brd_n and bwr_n are never low simultaneously.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, brd_n=1, bwr_n=1, bd_oe=0, zd_oe=0, busy=0, bd_out=0, zd_out=0, synchronizers=1.
REQ-028 Reset asserted mid-access SHALL abort the access at that edge; no partial strobe remains after it.

Configuration
REQ-029 Macro ZXNET_RDLATCH_EN (defined): zd_oe rises on the edge after capture and holds zd_out=captured data until the synced zrd_n=1, independent of the FSM state.
REQ-030 Macro undefined: no read register; zd_out=bd_in combinationally, and zd_oe=1 only while in STROBE for a read.

Structure
REQ-031 Package zxnet_bus_pkg SHALL hold the state enum, the phase counter width, and the parameter defaults.
REQ-032 One sub-module, sync_2ff (1-bit, reset value 1), instanced three times.

Verification
REQ-033 Write 0xA5, defaults: bwr_n low exactly 4 fclk from edge 4; bd_out=0xA5 with bd_oe=1 from edge 3 through 1 cycle after bwr_n rises.
REQ-034 Read with bd_in=0x3C, ZXNET_RDLATCH_EN defined: brd_n low 4 cycles; zd_out=0x3C with zd_oe=1 until zrd_n rises; checked at CPU 14 MHz and 28 MHz.
REQ-035 zrd_n pulse of 2 fclk: brd_n still low the full 4 cycles; FSM returns to IDLE; only one access.
REQ-036 zrd_n and zwr_n low together, or acc_sel=0: brd_n and bwr_n stay 1, busy stays 0.
REQ-037 rst_n=0 on the 2nd STROBE cycle: bwr_n=1, bd_oe=0, busy=0 at that edge; a following access works normally.
REQ-038 Long zwr_n (50 fclk) with SETUP_CYCLES=2, STB_CYCLES=6: a single bwr_n pulse of 6 cycles starting at edge 5; no retrigger.

Source files
------------

// File: rtl/zxnet_bus_pkg.sv
// Shared types and defaults for the Z80-to-peripheral bus strobe sequencer.
package zxnet_bus_pkg;

    localparam int PH_W             = 4;
    localparam int SETUP_CYCLES_DEF = 1;
    localparam int STB_CYCLES_DEF   = 4;
    localparam int HOLD_CYCLES_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_END = 3'd4
    } state_e;

endpackage

// File: rtl/bus_strobe_seq_sync_2ff.sv
// Single-bit two-flop synchronizer; both stages reset to 1 (inactive strobe level).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/bus_strobe_seq.sv
// Turns one raw Z80 read/write strobe into one timed peripheral strobe (setup/strobe/hold).
// Optional macro ZXNET_RDLATCH_EN adds a read-data latch driving zd_out until zrd_n rises.
module bus_strobe_seq
    import zxnet_bus_pkg::*;
#(
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    parameter int STB_CYCLES   = STB_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       zrd_n,
    input  logic       zwr_n,
    input  logic       acc_sel,
    input  logic [7:0] zd_in,
    output logic [7:0] zd_out,
    output logic       zd_oe,
    input  logic [7:0] bd_in,
    output logic [7:0] bd_out,
    output logic       bd_oe,
    output logic       brd_n,
    output logic       bwr_n,
    output logic       busy
);

    logic zrd_s, zwr_s, sel_s;

    sync_2ff u_sync_rd  (.clk(fclk), .rst_n(rst_n), .d(zrd_n),   .q(zrd_s));
    sync_2ff u_sync_wr  (.clk(fclk), .rst_n(rst_n), .d(zwr_n),   .q(zwr_s));
    sync_2ff u_sync_sel (.clk(fclk), .rst_n(rst_n), .d(acc_sel), .q(sel_s));

    state_e          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            rnw_q, rnw_d;
    logic [7:0]      bd_out_q, bd_out_d;
    logic            bd_oe_q, bd_oe_d;
    logic            brd_n_q, brd_n_d;
    logic            bwr_n_q, bwr_n_d;
    logic            last_ph;
    logic            cpu_stb_s;

    assign last_ph   = (ph_q == '0);
    assign cpu_stb_s = rnw_q ? zrd_s : zwr_s;

    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        bd_out_d = bd_out_q;
        ph_d     = ph_q;
        // Counter saturates at zero; each state entry reloads it.
        if (ph_q != '0) begin
            ph_d = ph_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (sel_s && (zrd_s ^ zwr_s)) begin
                    state_d = ST_SETUP;
                    rnw_d   = ~zrd_s;
                    ph_d    = PH_W'(SETUP_CYCLES - 1);
                    if (zrd_s) begin
                        bd_out_d = zd_in;
                    end
                end
            end
            ST_SETUP: begin
                if (last_ph) begin
                    state_d = ST_STROBE;
                    ph_d    = PH_W'(STB_CYCLES - 1);
                end
            end
            ST_STROBE: begin
                if (last_ph) begin
                    state_d = ST_HOLD;
                    ph_d    = PH_W'(HOLD_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (last_ph) begin
                    state_d = ST_WAIT_END;
                    ph_d    = '0;
                end
            end
            ST_WAIT_END: begin
                if (cpu_stb_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they change on the entry edge.
        brd_n_d = ~((state_d == ST_STROBE) && rnw_d);
        bwr_n_d = ~((state_d == ST_STROBE) && !rnw_d);
        bd_oe_d = !rnw_d && (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            rnw_q    <= 1'b0;
            bd_out_q <= 8'h00;
            bd_oe_q  <= 1'b0;
            brd_n_q  <= 1'b1;
            bwr_n_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            rnw_q    <= rnw_d;
            bd_out_q <= bd_out_d;
            bd_oe_q  <= bd_oe_d;
            brd_n_q  <= brd_n_d;
            bwr_n_q  <= bwr_n_d;
        end
    end

    assign bd_out = bd_out_q;
    assign bd_oe  = bd_oe_q;
    assign brd_n  = brd_n_q;
    assign bwr_n  = bwr_n_q;
    assign busy   = (state_q != ST_IDLE);

`ifdef ZXNET_RDLATCH_EN
    logic       cap_d, cap_q;
    logic [7:0] rd_d, rd_q;
    logic       zd_oe_d, zd_oe_q;

    // Latch persists past the FSM; only the CPU ending its read drops the enable.
    always_comb begin
        cap_d   = (state_q == ST_STROBE) && last_ph && rnw_q;
        rd_d    = cap_d ? bd_in : rd_q;
        zd_oe_d = zrd_s ? 1'b0 : (cap_q ? 1'b1 : zd_oe_q);
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            cap_q   <= 1'b0;
            rd_q    <= 8'h00;
            zd_oe_q <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            rd_q    <= rd_d;
            zd_oe_q <= zd_oe_d;
        end
    end

    assign zd_out = rd_q;
    assign zd_oe  = zd_oe_q;
`else
    assign zd_out = bd_in;
    assign zd_oe  = (state_q == ST_STROBE) && rnw_q;
`endif

endmodule
